uart_tx_scheduler: RTL and testbench

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_tx_scheduler.sv | 155 +++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler
// Purpose  : Queued 8N1 UART transmitter; back-to-back frames while the queue
//            holds data. Define UART_TX_PARITY_EN to add an even-parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler #(
    parameter int CLKS_PER_BIT = 22,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       busy,
    output logic       tx_done,
    output logic       tx
);

    localparam int                 c_PTR_W    = $clog2(FIFO_DEPTH);
    localparam int                 c_CNT_W    = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(FIFO_DEPTH);
    localparam logic [13:0]        c_BIT_MAX  = 14'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t             r_state, w_state_next;
    logic [13:0]        r_timer, w_timer_next;
    logic [2:0]         r_idx, w_idx_next;
    logic [7:0]         r_data, w_data_next;
    logic               r_tx, w_tx_next;
    logic               r_busy;
    logic               r_full;
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_CNT_W-1:0] r_count, w_count_next;
    logic               w_wr, w_pop, w_wrap, w_has_data;

    assign w_wrap       = (r_timer == c_BIT_MAX);
    assign w_has_data   = (r_count != '0);
    // Acceptance looks only at the registered full flag, so a write that
    // lands on the same edge as a pop from a full queue is dropped.
    assign w_wr         = wr_en & ~r_full;
    assign w_count_next = r_count + c_CNT_W'(w_wr) - c_CNT_W'(w_pop);

    always_comb begin
        w_state_next = r_state;
        w_data_next  = r_data;
        w_idx_next   = r_idx;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_has_data) begin
                    w_state_next = START;
                    w_pop        = 1'b1;
                    w_data_next  = r_mem[r_rd_ptr];
                end
            end
            START: begin
                if (w_wrap) w_state_next = DATA;
            end
            DATA: begin
                if (w_wrap) begin
                    w_idx_next = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_wrap) w_state_next = STOP;
            end
`endif
            STOP: begin
                if (w_wrap) begin
                    if (w_has_data) begin
                        w_state_next = START;
                        w_pop        = 1'b1;
                        w_data_next  = r_mem[r_rd_ptr];
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase

        if (r_state == IDLE || w_state_next != r_state || w_wrap) begin
            w_timer_next = '0;
        end else begin
            w_timer_next = r_timer + 14'd1;
        end

        // tx is registered from the next state so the line changes on the
        // same edge as the state it represents.
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_data_next[w_idx_next];
`ifdef UART_TX_PARITY_EN
            PARITY:  w_tx_next = ^r_data;
`endif
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_timer  <= '0;
            r_idx    <= '0;
            r_data   <= '0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_full   <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_next;
            r_timer  <= w_timer_next;
            r_idx    <= w_idx_next;
            r_data   <= w_data_next;
            r_tx     <= w_tx_next;
            r_busy   <= (w_state_next != IDLE);
            r_full   <= (w_count_next == c_FULL_CNT);
            r_count  <= w_count_next;
            if (w_wr)  r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= wr_data;
    end

    assign full    = r_full;
    assign busy    = r_busy;
    assign tx      = r_tx;
    assign tx_done = (r_state == STOP) && w_wrap;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_scheduler
// Purpose  : Directed self-checking bench for uart_tx_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_scheduler;

`ifdef UART_TX_PARITY_EN
    localparam int c_NBITS = 11;
`else
    localparam int c_NBITS = 10;
`endif

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en4, wr_en2;
    logic [7:0] wr_data4, wr_data2;
    logic       full4, busy4, tx_done4, tx4;
    logic       full2, busy2, tx_done2, tx2;
    logic       sel;
    logic       mon_tx, mon_busy, mon_done;
    int         n_checks = 0;
    int         n_fail   = 0;
    vec_t       vecs[5];

    always #5 clk = ~clk;

    uart_tx_scheduler #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut4 (
        .clk(clk), .reset(reset), .wr_en(wr_en4), .wr_data(wr_data4),
        .full(full4), .busy(busy4), .tx_done(tx_done4), .tx(tx4)
    );

    uart_tx_scheduler #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .reset(reset), .wr_en(wr_en2), .wr_data(wr_data2),
        .full(full2), .busy(busy2), .tx_done(tx_done2), .tx(tx2)
    );

    assign mon_tx   = sel ? tx2      : tx4;
    assign mon_busy = sel ? busy2    : busy4;
    assign mon_done = sel ? tx_done2 : tx_done4;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {2'b11, d, 1'b0};
`endif
    endfunction

    // Write one byte into the selected DUT; returns on the negedge after the
    // accepting edge, when the line must still be idle.
    task automatic write_byte(input logic [7:0] d);
        @(negedge clk);
        if (sel) begin wr_en2 = 1'b1; wr_data2 = d; end
        else     begin wr_en4 = 1'b1; wr_data4 = d; end
        @(negedge clk);
        wr_en2 = 1'b0;
        wr_en4 = 1'b0;
        check("tx idle on accept edge", {31'b0, mon_tx}, 32'd1);
    endtask

    // Expects the frame's start edge to be the next rising edge.
    task automatic run_frame(input logic [10:0] bits, input int cpb, input string name);
        for (int k = 0; k < c_NBITS * cpb; k++) begin
            @(negedge clk);
            check($sformatf("%s cyc%0d {tx,busy,done}", name, k),
                  {29'b0, mon_tx, mon_busy, mon_done},
                  {29'b0, bits[k / cpb], 1'b1, (k == c_NBITS * cpb - 1)});
        end
    endtask

    task automatic idle_check(input string name);
        @(negedge clk);
        check({name, " idle {tx,busy,done}"}, {29'b0, mon_tx, mon_busy, mon_done}, 32'b100);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] exp;
        int          bad;

        vecs[0] = '{8'hA5, 1'b0};
        vecs[1] = '{8'h07, 1'b1};
        vecs[2] = '{8'hFF, 1'b0};
        vecs[3] = '{8'h3C, 1'b0};
        vecs[4] = '{8'h01, 1'b1};

        reset = 1'b1; sel = 1'b0;
        wr_en4 = 1'b0; wr_data4 = '0; wr_en2 = 1'b0; wr_data2 = '0;
        repeat (3) @(negedge clk);
        check("reset dut4 {tx,busy,full,done}", {28'b0, tx4, busy4, full4, tx_done4}, 32'b1000);
        check("reset dut2 {tx,busy,full,done}", {28'b0, tx2, busy2, full2, tx_done2}, 32'b1000);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("no frame without write", {30'b0, tx4, busy4}, 32'b10);

        // Single frames from idle, table driven.
        for (int i = 0; i < 5; i++) begin
`ifdef UART_TX_PARITY_EN
            exp = {1'b1, vecs[i].par, vecs[i].data, 1'b0};
`else
            exp = {2'b11, vecs[i].data, 1'b0};
`endif
            write_byte(vecs[i].data);
            run_frame(exp, 4, $sformatf("vec%0d", i));
            idle_check($sformatf("vec%0d", i));
        end

        // Five writes during START: four queue, fifth dropped; then a write
        // on the STOP->START pop edge while full is also dropped.
        write_byte(8'h11);
        fork
            run_frame(frame_of(8'h11), 4, "b2b f0");
            begin
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk);
                    if (j == 3) check("full before 4th byte", {31'b0, full4}, 32'd0);
                    if (j == 4) check("full after 4th byte", {31'b0, full4}, 32'd1);
                    wr_en4   = 1'b1;
                    wr_data4 = 8'h21 + 8'(j);
                end
                @(negedge clk);
                wr_en4 = 1'b0;
                check("full holds after dropped write", {31'b0, full4}, 32'd1);
            end
        join
        check("full at pop edge", {31'b0, full4}, 32'd1);
        wr_en4 = 1'b1; wr_data4 = 8'h99;
        fork
            run_frame(frame_of(8'h21), 4, "b2b f1");
            begin
                @(negedge clk);
                wr_en4 = 1'b0;
                check("write on pop edge dropped (count 3)", {31'b0, full4}, 32'd0);
            end
        join
        run_frame(frame_of(8'h22), 4, "b2b f2");
        run_frame(frame_of(8'h23), 4, "b2b f3");
        run_frame(frame_of(8'h24), 4, "b2b f4");
        idle_check("b2b end");

        // Reset in DATA bit 3 with two bytes queued.
        write_byte(8'hA5);
        @(negedge clk); wr_en4 = 1'b1; wr_data4 = 8'h31;
        @(negedge clk); wr_data4 = 8'h32;
        @(negedge clk); wr_en4 = 1'b0;
        repeat (15) @(negedge clk);
        check("in data bit3 {tx,busy}", {30'b0, tx4, busy4}, 32'b01);
        #2 reset = 1'b1;
        #1 check("async reset {tx,busy,full,done}", {28'b0, tx4, busy4, full4, tx_done4}, 32'b1000);
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (tx4 !== 1'b1 || busy4 !== 1'b0) bad++;
        end
        check("queue discarded by reset (bad cycles)", 32'(bad), 32'd0);
        write_byte(8'h5A);
        run_frame(frame_of(8'h5A), 4, "post reset");
        idle_check("post reset");

        // Minimum bit time.
        sel = 1'b1;
        write_byte(8'h00);
        run_frame(frame_of(8'h00), 2, "cpb2");
        idle_check("cpb2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
